control_temporizador: RTL and testbench
=======================================

Name: control_temporizador

Overview:
- Programmable timer controller that sequences a tick prescaler (periodic clock-enable generator).
- Accepts a configuration over a valid/ready handshake: period in clk cycles, tick count, and mode (one-shot or continuous).
- Provides start/pause/resume/abort control and reports progress and completion.
- Sits between a host FSM or button/UART logic and any FPGA datapath that needs slow timed enables (LED blink, sampling, debouncing).

Parameters:
- ANCHO_DIV, 30, width of the period counter and of cfg_periodo.
- ANCHO_CNT, 16, width of the tick counter, cfg_pulsos and conteo.
- DIV_DEFECTO, 25000000, period latched at reset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  configuration can be accepted.
- cfg_periodo  in  ANCHO_DIV  tick period in clk cycles; 0 is treated as 1.
- cfg_pulsos  in  ANCHO_CNT  number of ticks in one-shot mode.
- cfg_continuo  in  1  1 = periodic forever, 0 = one-shot.
- iniciar  in  1  start, or resume from pause.
- pausar  in  1  freeze the prescaler.
- abortar  in  1  stop and discard the configuration.
- tick  out  1  one-cycle enable pulse.
- hecho  out  1  one-shot run complete (level).
- ocupado  out  1  high in RUN or PAUSE.
- conteo  out  ANCHO_CNT  one-shot: ticks remaining; continuous: ticks emitted.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, tick=0, hecho=0, ocupado=0, cfg_ready=1, conteo=0, periodo=DIV_DEFECTO, pulsos=0, continuo=0, prescaler=0.
- States: IDLE, ARMED, RUN, PAUSE, DONE.
- cfg_ready=1 in IDLE, ARMED and DONE; 0 in RUN and PAUSE. cfg_valid while ready is 0 is ignored.
- Handshake: accept on an edge with cfg_valid&cfg_ready.
  - Latch periodo (0 becomes 1), pulsos and continuo.
  - Go to ARMED; hecho cleared.
  - Re-configuring while in ARMED overwrites the latched values.
- Control priority: abortar > pausar > iniciar > cfg accept.
- iniciar in IDLE is ignored.
- iniciar in ARMED or DONE:
  - Go to RUN; prescaler cleared to 0.
  - conteo loaded with pulsos (one-shot) or 0 (continuous); hecho cleared.
- Tick timing (sub-module generador_tick):
  - In RUN the prescaler increments each edge, 0..periodo-1, then wraps to 0.
  - tick=1 during the cycle following the edge where the count wraps.
  - If iniciar is sampled at edge k, the first tick is high after edge k+periodo, then every periodo cycles.
  - periodo=1 gives tick high every cycle.
- One-shot accounting:
  - Each tick decrements conteo.
  - The edge issuing the tick that brings conteo 1->0 also moves the FSM to DONE: hecho=1, ocupado=0.
  - No further ticks are issued.
- One-shot with pulsos=0: iniciar moves directly to DONE at the next edge; no tick is issued.
- Continuous mode: each tick increments conteo, wrapping from 2^ANCHO_CNT-1 to 0; the FSM never reaches DONE.
- pausar in RUN:
  - At the sampling edge, go to PAUSE; the prescaler holds and tick=0.
  - A tick due on that same edge is suppressed and is instead issued on the first edge after resume.
- iniciar in PAUSE: go to RUN without clearing the prescaler; remaining phase is preserved.
- pausar outside RUN is ignored.
- abortar, any state: at the next edge go to IDLE.
  - tick=0, hecho=0, conteo=0, prescaler=0; latched config is retained but unusable until a new accept.
- Asynchronous reset mid-run: immediate return to reset values; no tick glitch after release.
- Wrap-around: the prescaler compare is performed at ANCHO_DIV width; no overflow is possible because periodo ≤ 2^ANCHO_DIV-1.

Decomposition:
- Shared package: state encoding localparams (IDLE, ARMED, RUN, PAUSE, DONE) and DIV_DEFECTO.
- One sub-module, generador_tick:
  - Inputs: clk, rst_n, clr, en, periodo.
  - Output: tick.
  - It is the periodic prescaler; the FSM, config registers and conteo live in control_temporizador.

Test Plan:
- Reset with rst_n=0 mid-RUN → all outputs at reset values immediately; cfg_ready=1.
- Config periodo=4, pulsos=3, one-shot, then iniciar at edge k:
  - tick after edges k+4, k+8, k+12.
  - conteo 3→2→1→0; hecho=1 and ocupado=0 from edge k+12.
  - No tick at k+16.
- Config periodo=1, continuous, then iniciar → tick high every cycle; conteo increments each cycle and wraps 65535→0.
- Pause/resume with periodo=5, pulsos=2:
  - pausar at prescaler count 2 and held 10 cycles → no ticks during the pause.
  - After iniciar, the first tick arrives exactly 3 cycles later.
- Conflicts:
  - cfg_valid during RUN → cfg_ready=0 and config unchanged.
  - abortar+pausar+iniciar same edge → IDLE.
  - pulsos=0 one-shot → DONE with zero ticks.
  - periodo=0 → behaves as 1.

Source files
------------

// File: rtl/control_temporizador_pkg.sv
// control_temporizador_pkg: shared state encoding and default tick period
package control_temporizador_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        RUN,
        PAUSE,
        DONE
    } estado_t;

    localparam int unsigned DIV_DEFECTO = 25000000;

endpackage

// File: rtl/control_temporizador_generador_tick.sv
// control_temporizador_generador_tick: periodic prescaler strobing tick on the edge its phase wraps
module control_temporizador_generador_tick #(
    parameter int ANCHO_DIV = 30
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic [ANCHO_DIV-1:0] periodo,
    output logic                 tick
);

    logic [ANCHO_DIV-1:0] cuenta_q;
    logic [ANCHO_DIV-1:0] cuenta_d;

    // tick is a strobe for the edge that wraps the phase; the caller registers it
    assign tick = en && (cuenta_q == periodo - ANCHO_DIV'(1));

    // phase advances only while enabled, so a pause freezes the remaining phase
    always_comb cuenta_d = clr ? '0 : !en ? cuenta_q : tick ? '0 : cuenta_q + ANCHO_DIV'(1);

    // phase register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cuenta_q <= '0;
        else
            cuenta_q <= cuenta_d;
    end

endmodule

// File: rtl/control_temporizador.sv
// control_temporizador: configurable one-shot/continuous timer sequencing a tick prescaler
module control_temporizador
    import control_temporizador_pkg::*;
#(
    parameter int          ANCHO_DIV   = 30,
    parameter int          ANCHO_CNT   = 16,
    parameter int unsigned DIV_DEFECTO = control_temporizador_pkg::DIV_DEFECTO
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [ANCHO_DIV-1:0] cfg_periodo,
    input  logic [ANCHO_CNT-1:0] cfg_pulsos,
    input  logic                 cfg_continuo,
    input  logic                 iniciar,
    input  logic                 pausar,
    input  logic                 abortar,
    output logic                 tick,
    output logic                 hecho,
    output logic                 ocupado,
    output logic [ANCHO_CNT-1:0] conteo
);

    estado_t              estado_q, estado_d;
    logic [ANCHO_DIV-1:0] periodo_q, periodo_d;
    logic [ANCHO_CNT-1:0] pulsos_q, pulsos_d;
    logic [ANCHO_CNT-1:0] conteo_q, conteo_d;
    logic                 continuo_q, continuo_d;
    logic                 tick_q, tick_d;
    logic                 hecho_q, hecho_d;
    logic                 ocupado_q, ocupado_d;
    logic                 cfg_ready_q, cfg_ready_d;
    logic                 arranca;
    logic                 en;
    logic                 vence;

    // a fresh start is only possible from a usable configuration; abort outranks it
    assign arranca = iniciar && !abortar && (estado_q == ARMED || estado_q == DONE);
    // the prescaler runs only on edges that keep the FSM in RUN
    assign en      = estado_q == RUN && !pausar && !abortar;

    control_temporizador_generador_tick #(
        .ANCHO_DIV(ANCHO_DIV)
    ) generador_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (abortar || arranca),
        .en      (en),
        .periodo (periodo_q),
        .tick    (vence)
    );

    // next state: abort > pause > start/resume > config accept > tick accounting
    always_comb begin
        estado_d   = estado_q;
        periodo_d  = periodo_q;
        pulsos_d   = pulsos_q;
        continuo_d = continuo_q;
        conteo_d   = conteo_q;
        hecho_d    = hecho_q;
        if (abortar) begin
            estado_d = IDLE;
            conteo_d = '0;
            hecho_d  = 1'b0;
        end else if (estado_q == RUN && pausar) begin
            estado_d = PAUSE;
        end else if (arranca) begin
            hecho_d  = !continuo_q && pulsos_q == '0;
            estado_d = hecho_d ? DONE : RUN;
            conteo_d = continuo_q ? '0 : pulsos_q;
        end else if (iniciar && estado_q == PAUSE) begin
            estado_d = RUN;
        end else if (cfg_valid && cfg_ready_q) begin
            periodo_d  = cfg_periodo == '0 ? ANCHO_DIV'(1) : cfg_periodo;
            pulsos_d   = cfg_pulsos;
            continuo_d = cfg_continuo;
            estado_d   = ARMED;
            hecho_d    = 1'b0;
        end else if (vence) begin
            conteo_d = continuo_q ? conteo_q + ANCHO_CNT'(1) : conteo_q - ANCHO_CNT'(1);
            if (!continuo_q && conteo_q == ANCHO_CNT'(1)) begin
                estado_d = DONE;
                hecho_d  = 1'b1;
            end
        end
    end

    // registered outputs follow the next state so they line up with it
    always_comb begin
        tick_d      = vence;
        ocupado_d   = estado_d == RUN || estado_d == PAUSE;
        cfg_ready_d = !ocupado_d;
    end

    // state, configuration and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= IDLE;
            periodo_q   <= ANCHO_DIV'(DIV_DEFECTO);
            pulsos_q    <= '0;
            continuo_q  <= 1'b0;
            conteo_q    <= '0;
            tick_q      <= 1'b0;
            hecho_q     <= 1'b0;
            ocupado_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            estado_q    <= estado_d;
            periodo_q   <= periodo_d;
            pulsos_q    <= pulsos_d;
            continuo_q  <= continuo_d;
            conteo_q    <= conteo_d;
            tick_q      <= tick_d;
            hecho_q     <= hecho_d;
            ocupado_q   <= ocupado_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign tick      = tick_q;
    assign hecho     = hecho_q;
    assign ocupado   = ocupado_q;
    assign conteo    = conteo_q;

endmodule

// File: tb/tb_control_temporizador.sv
// tb_control_temporizador: directed scenarios plus randomized run against a behavioural timer model
module tb_control_temporizador;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [29:0] cfg_periodo = '0;
    logic [15:0] cfg_pulsos = '0;
    logic        cfg_continuo = 1'b0;
    logic        iniciar = 1'b0;
    logic        pausar = 1'b0;
    logic        abortar = 1'b0;
    logic        cfg_ready;
    logic        tick;
    logic        hecho;
    logic        ocupado;
    logic [15:0] conteo;

    int checks = 0;
    int errors = 0;

    // behavioural model: running/paused flags, cycles left to next tick, usable-config flag
    bit          m_run, m_pause, m_listo, m_hecho, m_tick, m_cont;
    int          m_per, m_rest;
    logic [15:0] m_pul, m_conteo;

    always #5 clk = ~clk;

    control_temporizador dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_periodo  (cfg_periodo),
        .cfg_pulsos   (cfg_pulsos),
        .cfg_continuo (cfg_continuo),
        .iniciar      (iniciar),
        .pausar       (pausar),
        .abortar      (abortar),
        .tick         (tick),
        .hecho        (hecho),
        .ocupado      (ocupado),
        .conteo       (conteo)
    );

    task automatic modelo_reset();
        m_run = 0; m_pause = 0; m_listo = 0; m_hecho = 0; m_tick = 0; m_cont = 0;
        m_per = 25000000; m_rest = 0; m_pul = 0; m_conteo = 0;
    endtask

    task automatic modelo_paso();
        bit libre;
        libre  = !(m_run || m_pause);
        m_tick = 0;
        if (abortar) begin
            m_run = 0; m_pause = 0; m_listo = 0; m_hecho = 0; m_conteo = 0;
        end else if (m_run && pausar) begin
            m_run = 0; m_pause = 1;
        end else if (iniciar && m_listo && libre) begin
            m_conteo = m_cont ? 16'd0 : m_pul;
            m_hecho  = !m_cont && m_pul == 0;
            m_run    = !m_hecho;
            m_rest   = m_per;
        end else if (iniciar && m_pause) begin
            m_pause = 0; m_run = 1;
        end else if (cfg_valid && libre) begin
            m_per   = cfg_periodo == 0 ? 1 : int'(cfg_periodo);
            m_pul   = cfg_pulsos;
            m_cont  = cfg_continuo;
            m_listo = 1; m_hecho = 0;
        end else if (m_run) begin
            m_rest--;
            if (m_rest == 0) begin
                m_tick = 1;
                m_rest = m_per;
                if (m_cont) m_conteo++;
                else begin
                    m_conteo--;
                    if (m_conteo == 0) begin m_run = 0; m_hecho = 1; end
                end
            end
        end
    endtask

    task automatic ciclo();
        @(posedge clk);
        modelo_paso();
        #1;
    endtask

    task automatic configurar(input int per, input int pul, input bit cont);
        cfg_valid = 1; cfg_periodo = 30'(per); cfg_pulsos = 16'(pul); cfg_continuo = cont;
        ciclo();
        cfg_valid = 0;
    endtask

    task automatic arrancar();
        iniciar = 1;
        ciclo();
        iniciar = 0;
    endtask

    task automatic test_reset();
        #1 rst_n = 0;
        #1;
        checks++;
        if ({tick, hecho, ocupado, cfg_ready, conteo} !== {4'b0001, 16'd0}) begin
            errors++;
            $display("FAIL reset_values got %b_%0d want 0001_0", {tick, hecho, ocupado, cfg_ready}, conteo);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        modelo_reset();
        arrancar();
        checks++;
        if (ocupado !== 1'b0) begin
            errors++;
            $display("FAIL start_without_cfg ocupado got %b want 0", ocupado);
        end
    endtask

    task automatic test_one_shot();
        configurar(4, 3, 0);
        arrancar();
        checks++;
        if ({tick, hecho, ocupado, conteo} !== {3'b001, 16'd3}) begin
            errors++;
            $display("FAIL oneshot_start got %b_%0d want 001_3", {tick, hecho, ocupado}, conteo);
        end
        for (int e = 1; e <= 16; e++) begin
            bit          t;
            logic [15:0] c;
            ciclo();
            t = (e % 4 == 0) && e <= 12;
            c = 16'(e >= 12 ? 0 : 3 - e / 4);
            checks++;
            if ({tick, hecho, ocupado, conteo} !== {t, e >= 12, e < 12, c}) begin
                errors++;
                $display("FAIL oneshot_edge%0d got %b_%0d want %b_%0d", e, {tick, hecho, ocupado}, conteo,
                         {t, e >= 12, e < 12}, c);
            end
        end
    endtask

    task automatic test_continuous();
        configurar(1, 7, 1);
        arrancar();
        for (int i = 1; i <= 65537; i++) begin
            ciclo();
            if (i < 5 || i > 65533) begin
                checks++;
                if ({tick, ocupado, conteo} !== {2'b11, 16'(i)}) begin
                    errors++;
                    $display("FAIL cont_cycle%0d got %b_%0d want 11_%0d", i, {tick, ocupado}, conteo, 16'(i));
                end
            end
        end
        abortar = 1;
        ciclo();
        abortar = 0;
        checks++;
        if ({tick, hecho, ocupado, cfg_ready, conteo} !== {4'b0001, 16'd0}) begin
            errors++;
            $display("FAIL cont_abort got %b_%0d want 0001_0", {tick, hecho, ocupado, cfg_ready}, conteo);
        end
    endtask

    task automatic test_pause_resume();
        configurar(5, 2, 0);
        arrancar();
        repeat (2) ciclo();
        pausar = 1;
        for (int j = 0; j < 10; j++) begin
            ciclo();
            checks++;
            if ({tick, ocupado, cfg_ready} !== 3'b010) begin
                errors++;
                $display("FAIL pause_cycle%0d got %b want 010", j, {tick, ocupado, cfg_ready});
            end
        end
        pausar = 0;
        arrancar();
        for (int j = 1; j <= 3; j++) begin
            ciclo();
            checks++;
            if ({tick, conteo} !== {j == 3, 16'(j == 3 ? 1 : 2)}) begin
                errors++;
                $display("FAIL resume_cycle%0d got %b_%0d want %b_%0d", j, tick, conteo, j == 3, j == 3 ? 1 : 2);
            end
        end
        repeat (5) ciclo();
        checks++;
        if ({tick, hecho, ocupado, conteo} !== {3'b110, 16'd0}) begin
            errors++;
            $display("FAIL pause_done got %b_%0d want 110_0", {tick, hecho, ocupado}, conteo);
        end
    endtask

    task automatic test_conflicts();
        configurar(3, 2, 0);
        arrancar();
        cfg_valid = 1; cfg_periodo = 30'd7; cfg_pulsos = 16'd9; cfg_continuo = 1;
        ciclo();
        cfg_valid = 0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_run got %b want 0", cfg_ready);
        end
        for (int j = 2; j <= 6; j++) begin
            logic [15:0] c;
            ciclo();
            c = 16'(j < 3 ? 2 : j < 6 ? 1 : 0);
            checks++;
            if ({tick, hecho, conteo} !== {j % 3 == 0, j == 6, c}) begin
                errors++;
                $display("FAIL cfg_ignored_edge%0d got %b_%0d want %b_%0d", j, {tick, hecho}, conteo,
                         {j % 3 == 0, j == 6}, c);
            end
        end
        arrancar();
        ciclo();
        abortar = 1; pausar = 1; iniciar = 1;
        ciclo();
        abortar = 0; pausar = 0; iniciar = 0;
        checks++;
        if ({tick, hecho, ocupado, cfg_ready, conteo} !== {4'b0001, 16'd0}) begin
            errors++;
            $display("FAIL abort_priority got %b_%0d want 0001_0", {tick, hecho, ocupado, cfg_ready}, conteo);
        end
        arrancar();
        checks++;
        if (ocupado !== 1'b0) begin
            errors++;
            $display("FAIL start_after_abort ocupado got %b want 0", ocupado);
        end
        configurar(2, 0, 0);
        arrancar();
        checks++;
        if ({tick, hecho, ocupado, conteo} !== {3'b010, 16'd0}) begin
            errors++;
            $display("FAIL zero_pulses got %b_%0d want 010_0", {tick, hecho, ocupado}, conteo);
        end
        for (int j = 0; j < 6; j++) begin
            ciclo();
            checks++;
            if (tick !== 1'b0) begin
                errors++;
                $display("FAIL zero_pulses_tick%0d got %b want 0", j, tick);
            end
        end
        configurar(0, 3, 0);
        arrancar();
        for (int j = 1; j <= 3; j++) begin
            ciclo();
            checks++;
            if ({tick, hecho, conteo} !== {1'b1, j == 3, 16'(3 - j)}) begin
                errors++;
                $display("FAIL period0_edge%0d got %b_%0d want %b_%0d", j, {tick, hecho}, conteo,
                         {1'b1, j == 3}, 3 - j);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        configurar(2, 5, 0);
        arrancar();
        repeat (2) ciclo();
        checks++;
        if (tick !== 1'b1) begin
            errors++;
            $display("FAIL midrun_pre_tick got %b want 1", tick);
        end
        rst_n = 0;
        #1;
        checks++;
        if ({tick, hecho, ocupado, cfg_ready, conteo} !== {4'b0001, 16'd0}) begin
            errors++;
            $display("FAIL midrun_reset got %b_%0d want 0001_0", {tick, hecho, ocupado, cfg_ready}, conteo);
        end
        modelo_reset();
        @(negedge clk);
        rst_n = 1;
        for (int j = 0; j < 4; j++) begin
            ciclo();
            checks++;
            if ({tick, ocupado, cfg_ready} !== 3'b001) begin
                errors++;
                $display("FAIL post_reset_cycle%0d got %b want 001", j, {tick, ocupado, cfg_ready});
            end
        end
    endtask

    task automatic test_random();
        rst_n = 0;
        #1;
        modelo_reset();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 1500; i++) begin
            cfg_valid    = $urandom_range(0, 3) == 0;
            cfg_periodo  = 30'($urandom_range(0, 6));
            cfg_pulsos   = 16'($urandom_range(0, 4));
            cfg_continuo = $urandom_range(0, 3) == 0;
            iniciar      = $urandom_range(0, 4) == 0;
            pausar       = $urandom_range(0, 9) == 0;
            abortar      = $urandom_range(0, 39) == 0;
            ciclo();
            checks++;
            if ({tick, hecho, ocupado, cfg_ready, conteo} !==
                {m_tick, m_hecho, m_run || m_pause, !(m_run || m_pause), m_conteo}) begin
                errors++;
                $display("FAIL random_cycle%0d got %b_%0d want %b_%0d", i, {tick, hecho, ocupado, cfg_ready}, conteo,
                         {m_tick, m_hecho, m_run || m_pause, !(m_run || m_pause)}, m_conteo);
            end
        end
        cfg_valid = 0; iniciar = 0; pausar = 0; abortar = 0;
    endtask

    initial begin
        modelo_reset();
        test_reset();
        test_one_shot();
        test_continuous();
        test_pause_resume();
        test_conflicts();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
